// File: rtl/result_reporter_pkg.sv
// Shared types, ASCII constants and hex encoding for the result reporter.
// Used by the report FSM and its UART byte issuer.
package result_reporter_pkg;

    typedef enum logic [2:0] {
        WAIT_DONE,
        SEND_TAG,
        SEND_HEX,
        SEND_EOL,
        SEND_END,
        FINISHED
    } state_e;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [23:0] ASCII_END  = "END";

    localparam int K_W  = 4;
    localparam int CI_W = 4;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_ZERO + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/tx_byte_if.sv
// Byte valid/ready handshake between the report FSM and the UART issuer.
// The source holds data stable while valid is high and ready is low.
interface tx_byte_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport src (
        output valid,
        output data,
        input  ready
    );

    modport sink (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/tx_byte_issuer.sv
// Turns accepted bytes into one-cycle tx_send pulses for the UART.
// Never launches in the cycle right after a pulse, before tx_busy can react.
module tx_byte_issuer
    import result_reporter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_send,
    tx_byte_if.sink    bif
);

    logic fire;

    assign bif.ready = !tx_busy && !tx_send;
    assign fire      = bif.valid && bif.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= 8'h00;
            tx_send <= 1'b0;
        end else begin
            tx_send <= fire;
            if (fire) begin
                tx_data <= bif.data;
            end
        end
    end

endmodule

// File: rtl/result_reporter.sv
// Streams a snapshot of result words as "Rk:HEX\r\n" lines plus "END\r\n".
// Define RESULT_REPORTER_REARM_EN to allow repeated reports after done_val drops.
module result_reporter
    import result_reporter_pkg::*;
#(
    parameter logic [31:0] DONE_MAGIC = 32'hDEADBEEF,
    parameter int          NUM_WORDS  = 4,
    parameter int          WORD_W     = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 done_val,
    input  logic [NUM_WORDS*WORD_W-1:0] result_vals,
    output logic [7:0]                  tx_data,
    output logic                        tx_send,
    input  logic                        tx_busy,
    output logic                        report_active,
    output logic                        report_done
);

    localparam int ND   = WORD_W / 4;
    localparam int RV_W = NUM_WORDS * WORD_W;

    state_e            state;
    logic [RV_W-1:0]   snap;
    logic [K_W-1:0]    k_q;
    logic [CI_W-1:0]   ci_q;
    logic [WORD_W-1:0] cur_word;
    logic [3:0]        nib;
    logic [7:0]        cur_byte;
    logic              accept;

    tx_byte_if bif ();

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (k_q == K_W'(i)) begin
                cur_word = snap[i*WORD_W +: WORD_W];
            end
        end
    end

    // char index 0 is the most significant nibble
    always_comb begin
        nib = '0;
        for (int j = 0; j < ND; j++) begin
            if (ci_q == CI_W'(ND - 1 - j)) begin
                nib = cur_word[j*4 +: 4];
            end
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        unique case (state)
            SEND_TAG: begin
                unique case (1'b1)
                    (ci_q == CI_W'(0)): cur_byte = ASCII_R;
                    (ci_q == CI_W'(1)): cur_byte = ASCII_ZERO + {4'h0, k_q};
                    default:            cur_byte = ASCII_COLON;
                endcase
            end
            SEND_HEX: cur_byte = hex_char(nib);
            SEND_EOL: cur_byte = (ci_q == '0) ? ASCII_CR : ASCII_LF;
            SEND_END: begin
                unique case (1'b1)
                    (ci_q == CI_W'(0)): cur_byte = ASCII_END[23:16];
                    (ci_q == CI_W'(1)): cur_byte = ASCII_END[15:8];
                    (ci_q == CI_W'(2)): cur_byte = ASCII_END[7:0];
                    (ci_q == CI_W'(3)): cur_byte = ASCII_CR;
                    default:            cur_byte = ASCII_LF;
                endcase
            end
            default: cur_byte = 8'h00;
        endcase
    end

    assign bif.valid = (state == SEND_TAG) || (state == SEND_HEX) ||
                       (state == SEND_EOL) || (state == SEND_END);
    assign bif.data  = cur_byte;
    assign accept    = bif.valid && bif.ready;

    tx_byte_issuer u_issuer (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_busy (tx_busy),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .bif     (bif)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_DONE;
            snap          <= '0;
            k_q           <= '0;
            ci_q          <= '0;
            report_active <= 1'b0;
            report_done   <= 1'b0;
        end else begin
            unique case (state)
                WAIT_DONE: begin
                    if (done_val == DONE_MAGIC) begin
                        snap          <= result_vals;
                        k_q           <= '0;
                        ci_q          <= '0;
                        report_active <= 1'b1;
                        state         <= SEND_TAG;
                    end
                end
                SEND_TAG: begin
                    if (accept) begin
                        if (ci_q == CI_W'(2)) begin
                            ci_q  <= '0;
                            state <= SEND_HEX;
                        end else begin
                            ci_q <= ci_q + CI_W'(1);
                        end
                    end
                end
                SEND_HEX: begin
                    if (accept) begin
                        if (ci_q == CI_W'(ND - 1)) begin
                            ci_q  <= '0;
                            state <= SEND_EOL;
                        end else begin
                            ci_q <= ci_q + CI_W'(1);
                        end
                    end
                end
                SEND_EOL: begin
                    if (accept) begin
                        if (ci_q == CI_W'(1)) begin
                            ci_q <= '0;
                            if (k_q == K_W'(NUM_WORDS - 1)) begin
                                state <= SEND_END;
                            end else begin
                                k_q   <= k_q + K_W'(1);
                                state <= SEND_TAG;
                            end
                        end else begin
                            ci_q <= ci_q + CI_W'(1);
                        end
                    end
                end
                SEND_END: begin
                    if (accept) begin
                        if (ci_q == CI_W'(4)) begin
                            ci_q          <= '0;
                            report_active <= 1'b0;
                            report_done   <= 1'b1;
                            state         <= FINISHED;
                        end else begin
                            ci_q <= ci_q + CI_W'(1);
                        end
                    end
                end
                FINISHED: begin
`ifdef RESULT_REPORTER_REARM_EN
                    if (done_val != DONE_MAGIC) begin
                        report_done <= 1'b0;
                        state       <= WAIT_DONE;
                    end
`else
                    state <= FINISHED;
`endif
                end
                default: state <= WAIT_DONE;
            endcase
        end
    end

endmodule
